// File: rtl/ser_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : ser_cmd_master
// Purpose  : Upstream driver for the serial memory slave. Turns parallel
//            read/write requests into contiguous fixed-length serial frames
//            on sdo and captures read data returned on sdi. Frames never
//            stop; idle slots carry all-zero NOP frames.
// Ports    : clk, rst (sync, active-high)
//            req_valid/req_ready/req_we/req_addr/req_wdata : command input
//            rsp_valid/rsp_rdata : read response (1-cycle pulse, held data)
//            sdo : serial out to slave din (flop output)
//            sdi : serial in from slave dout
//            frame_sof : high during slot 0 of every frame
// Config   : SER_MASTER_FIFO_EN - replaces the single hold register with a
//            4-entry command FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ser_cmd_master #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int PAD_BITS = 2,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sdo,
  input  logic              sdi,
  output logic              frame_sof
);

  localparam int              c_FRAME     = ADDR_W + 1 + PAD_BITS + DATA_W + 1;
  localparam int              c_KW        = $clog2(c_FRAME);
  localparam logic [c_KW-1:0] c_K_LAST    = c_KW'(c_FRAME - 1);
  // Read data arrives RD_LAT cycles after the matching data-bit slot.
  localparam logic [c_KW-1:0] c_CAP_FIRST = c_KW'(ADDR_W + 1 + PAD_BITS + RD_LAT);
  localparam logic [c_KW-1:0] c_CAP_LAST  = c_KW'(ADDR_W + PAD_BITS + DATA_W + RD_LAT);

  typedef enum logic [1:0] {
    RUN_NOP = 2'd0,
    RUN_RD  = 2'd1,
    RUN_WR  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_KW-1:0]     r_k;
  logic [c_FRAME-1:0]  r_sr;
  logic                r_sof;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_cap;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_launch;
  logic                w_fire;
  logic                w_bypass;
  logic                w_push;
  logic                w_pop;
  logic                w_q_valid;
  logic                w_q_we;
  logic [ADDR_W-1:0]   w_q_addr;
  logic [DATA_W-1:0]   w_q_wdata;
  logic                w_ld_valid;
  logic                w_ld_we;
  logic [ADDR_W-1:0]   w_ld_addr;
  logic [DATA_W-1:0]   w_ld_wdata;
  logic [c_FRAME-1:0]  w_ld_frame;
  logic                w_cap_en;
  logic                w_cap_last;

  assign w_launch = (r_k == c_K_LAST);
  assign w_fire   = req_valid & req_ready;
  // A request may skip the queue only when nothing is waiting ahead of it.
  assign w_bypass = w_launch & w_fire & ~w_q_valid;
  assign w_push   = w_fire & ~w_bypass;
  assign w_pop    = w_launch & w_q_valid;

`ifdef SER_MASTER_FIFO_EN
  localparam int c_DEPTH = 4;

  logic              r_fifo_we    [c_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr  [c_DEPTH];
  logic [DATA_W-1:0] r_fifo_wdata [c_DEPTH];
  logic [1:0]        r_wp;
  logic [1:0]        r_rp;
  logic [2:0]        r_cnt;

  assign w_q_valid = (r_cnt != 3'd0);
  assign w_q_we    = r_fifo_we[r_rp];
  assign w_q_addr  = r_fifo_addr[r_rp];
  assign w_q_wdata = r_fifo_wdata[r_rp];
  // When full, the launch slot pops the head, so a push can share that cycle.
  assign req_ready = (r_cnt != 3'd4) | w_launch;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_we[r_wp]    <= req_we;
      r_fifo_addr[r_wp]  <= req_addr;
      r_fifo_wdata[r_wp] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  logic              r_hold_valid;
  logic              r_hold_we;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_wdata;

  assign w_q_valid = r_hold_valid;
  assign w_q_we    = r_hold_we;
  assign w_q_addr  = r_hold_addr;
  assign w_q_wdata = r_hold_wdata;
  assign req_ready = ~r_hold_valid;

  always_ff @(posedge clk) begin
    if (rst)         r_hold_valid <= 1'b0;
    else if (w_push) r_hold_valid <= 1'b1;
    else if (w_pop)  r_hold_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hold_we    <= req_we;
      r_hold_addr  <= req_addr;
      r_hold_wdata <= req_wdata;
    end
  end
`endif

  // Next-frame source: queued command first, then a bypassing request,
  // otherwise a NOP (read of address 0 with all bits zero).
  always_comb begin
    w_ld_valid = 1'b0;
    w_ld_we    = 1'b0;
    w_ld_addr  = '0;
    w_ld_wdata = '0;
    if (w_q_valid) begin
      w_ld_valid = 1'b1;
      w_ld_we    = w_q_we;
      w_ld_addr  = w_q_addr;
      w_ld_wdata = w_q_wdata;
    end else if (w_fire) begin
      w_ld_valid = 1'b1;
      w_ld_we    = req_we;
      w_ld_addr  = req_addr;
      w_ld_wdata = req_wdata;
    end
  end

  assign w_ld_frame = {w_ld_addr, w_ld_we, {PAD_BITS{1'b0}},
                       (w_ld_we ? w_ld_wdata : {DATA_W{1'b0}}), 1'b0};

  assign w_cap_en   = (r_state == RUN_RD) && (r_k >= c_CAP_FIRST) && (r_k <= c_CAP_LAST);
  assign w_cap_last = (r_state == RUN_RD) && (r_k == c_CAP_LAST);

  // The whole frame is parallel-loaded into a shift register at the launch
  // slot, so sdo is a flop output already aligned with slot counter value k.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_state     <= RUN_NOP;
      r_sr        <= '0;
      r_sof       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_cap       <= '0;
      r_rdata     <= '0;
    end else begin
      r_k         <= w_launch ? '0 : r_k + 1'b1;
      r_sof       <= w_launch;
      r_rsp_valid <= 1'b0;
      if (w_launch) begin
        r_sr <= w_ld_frame;
        if (!w_ld_valid)   r_state <= RUN_NOP;
        else if (w_ld_we)  r_state <= RUN_WR;
        else               r_state <= RUN_RD;
      end else begin
        r_sr <= {r_sr[c_FRAME-2:0], 1'b0};
      end
      if (w_cap_en) r_cap <= {r_cap[DATA_W-2:0], sdi};
      if (w_cap_last) begin
        r_rsp_valid <= 1'b1;
        r_rdata     <= {r_cap[DATA_W-2:0], sdi};
      end
    end
  end

  assign sdo       = r_sr[c_FRAME-1];
  assign frame_sof = r_sof;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ser_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser_cmd_master
// Purpose  : Self-checking bench for ser_cmd_master with a behavioural serial
//            slave (read latency 1) and a read-data scoreboard.
// Config   : SER_MASTER_FIFO_EN enables the FIFO scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser_cmd_master;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  k;
    logic [15:0] d;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        sdo;
  logic        sdi;
  logic        frame_sof;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] r_cyc = '0;

  logic [15:0] exp_q[$];
  obs_t        obs_q[$];
  logic [24:0] frame_q[$];
  logic [15:0] model_mem [32];

  logic [4:0]  r_k;
  logic [4:0]  r_s_addr;
  logic        r_s_we;
  logic [15:0] r_s_wd;
  logic [15:0] r_mem [32];
  logic [23:0] r_obs;

  ser_cmd_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sdo       (sdo),
    .sdi       (sdi),
    .frame_sof (frame_sof)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'((i * 291) ^ 16'h5A5A);
  endfunction

  always @(posedge clk) r_cyc <= r_cyc + 32'd1;

  // Serial slave: r_k is the bench's own slot count for the current cycle.
  always @(posedge clk) begin
    if (rst) begin
      r_k <= 5'd0;
      sdi <= 1'b0;
      for (int i = 0; i < 32; i++) r_mem[i] <= init_val(i);
    end else begin
      r_k <= (r_k == 5'd24) ? 5'd0 : r_k + 5'd1;
      if (r_k <= 5'd4) r_s_addr <= {r_s_addr[3:0], sdo};
      if (r_k == 5'd5) r_s_we <= sdo;
      if (r_k >= 5'd8 && r_k <= 5'd23) r_s_wd <= {r_s_wd[14:0], sdo};
      if (r_k == 5'd24 && r_s_we) r_mem[r_s_addr] <= r_s_wd;
      if (r_k >= 5'd8 && r_k <= 5'd23 && !r_s_we)
        sdi <= r_mem[r_s_addr][4'(5'd23 - r_k)];
      else
        sdi <= 1'b0;
    end
  end

  // Observers: completed frames and read responses.
  always @(negedge clk) begin
    if (!rst) begin
      r_obs <= {r_obs[22:0], sdo};
      if (r_k == 5'd24) frame_q.push_back({r_obs, sdo});
      if (rsp_valid) obs_q.push_back({r_cyc, r_k, rsp_rdata});
    end
  end

  task automatic send(input logic we, input logic [4:0] a, input logic [15:0] d,
                      output int waited);
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: req_ready never rose for addr %h", a);
    end else if (we) begin
      model_mem[a] = d;
    end else begin
      exp_q.push_back(model_mem[a]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic next_frame(output logic [24:0] f);
    int n = 0;
    while (frame_q.size() == 0 && n < 60) begin @(posedge clk); n++; end
    if (frame_q.size() == 0) begin
      checks++; errors++; f = '0;
      $display("FAIL frame_timeout: no frame completed in 60 cycles");
    end else begin
      f = frame_q.pop_front();
    end
  endtask

  task automatic next_rsp(output obs_t o, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 100) begin @(posedge clk); n++; end
    ok = (obs_q.size() != 0);
    if (!ok) begin
      checks++; errors++; o = '0;
      $display("FAIL rsp_timeout: no rsp_valid in 100 cycles");
    end else begin
      o = obs_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
    exp_q.delete(); obs_q.delete(); frame_q.delete();
    checks++; if (frame_sof !== 1'b1) begin errors++; $display("FAIL reset_sof: got %b want 1", frame_sof); end
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", sdo); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_idle();
    int sof_cnt = 0;
    int bad_sdo = 0, bad_sof = 0, bad_rsp = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_sof === 1'b1) sof_cnt++;
      if (sdo !== 1'b0) bad_sdo++;
      if (frame_sof !== (r_k == 5'd0)) bad_sof++;
      if (rsp_valid !== 1'b0) bad_rsp++;
    end
    @(posedge clk);
    checks++; if (bad_sdo != 0) begin errors++; $display("FAIL idle_sdo: %0d nonzero cycles, want 0", bad_sdo); end
    checks++; if (bad_sof != 0) begin errors++; $display("FAIL idle_sof_align: %0d misaligned cycles, want 0", bad_sof); end
    checks++; if (sof_cnt != 4) begin errors++; $display("FAIL idle_sof_count: got %0d want 4", sof_cnt); end
    checks++; if (bad_rsp != 0 || obs_q.size() != 0) begin errors++; $display("FAIL idle_rsp: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_write();
    logic [24:0] f;
    logic [24:0] exp_f;
    int w;
    exp_f = {5'h13, 1'b1, 2'b00, 16'hA5C3, 1'b0};
    do @(negedge clk); while (r_k != 5'd23);
    send(1'b1, 5'h13, 16'hA5C3, w);
    frame_q.delete();
    checks++; if (w != 0) begin errors++; $display("FAIL write_k24_accept: waited %0d want 0", w); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL write_bypass_ready: got %b want 1", req_ready); end
    next_frame(f);
    checks++; if (f !== exp_f) begin errors++; $display("FAIL write_frame: got %h want %h", f, exp_f); end
    next_frame(f);
    checks++; if (f !== 25'h0) begin errors++; $display("FAIL write_nop_after: got %h want 0", f); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL write_no_rsp: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_read();
    logic [24:0] f;
    logic [24:0] exp_f;
    logic [15:0] e;
    obs_t o;
    bit ok;
    int w;
    exp_f = {5'h13, 1'b0, 2'b00, 16'h0, 1'b0};
    @(posedge clk);
    frame_q.delete(); obs_q.delete();
    send(1'b0, 5'h13, 16'hFFFF, w);
    f = '0;
    for (int i = 0; i < 3 && f == 25'h0; i++) next_frame(f);
    checks++; if (f !== exp_f) begin errors++; $display("FAIL read_frame: got %h want %h", f, exp_f); end
    next_rsp(o, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (o.d !== e) begin errors++; $display("FAIL read_data: got %h want %h", o.d, e); end
      checks++; if (o.k !== 5'd0) begin errors++; $display("FAIL read_rsp_slot: got k=%0d want 0", o.k); end
    end
    repeat (30) @(negedge clk);
    checks++; if (rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL read_hold: got %h want a5c3", rsp_rdata); end
    @(posedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL read_single_pulse: got %0d extra want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [4:0] addrs [3];
    logic [31:0] t [3];
    logic [15:0] e;
    obs_t o;
    bit ok;
    int w [3];
    addrs[0] = 5'h03; addrs[1] = 5'h07; addrs[2] = 5'h1F;
    @(posedge clk);
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) send(1'b0, addrs[i], 16'h0, w[i]);
`ifndef SER_MASTER_FIFO_EN
    checks++; if (w[2] == 0) begin errors++; $display("FAIL b2b_ready_low: third request waited %0d want >0", w[2]); end
`endif
    for (int i = 0; i < 3; i++) begin
      t[i] = '0;
      next_rsp(o, ok);
      if (ok) begin
        t[i] = o.cyc;
        e = exp_q.pop_front();
        checks++; if (o.d !== e) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, o.d, e); end
      end
    end
    checks++; if (t[1] - t[0] != 32'd25) begin errors++; $display("FAIL b2b_spacing01: got %0d want 25", t[1] - t[0]); end
    checks++; if (t[2] - t[1] != 32'd25) begin errors++; $display("FAIL b2b_spacing12: got %0d want 25", t[2] - t[1]); end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    int bad_sdo = 0;
    @(posedge clk);
    send(1'b0, 5'h04, 16'h0, w);
    send(1'b0, 5'h09, 16'h0, w);
    do @(negedge clk); while (r_k != 5'd12);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL midrst_sdo: got %b want 0", sdo); end
    checks++; if (frame_sof !== 1'b1) begin errors++; $display("FAIL midrst_sof: got %b want 1", frame_sof); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); frame_q.delete();
    for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sdo !== 1'b0) bad_sdo++;
    end
    @(posedge clk);
    checks++; if (bad_sdo != 0) begin errors++; $display("FAIL midrst_dropped: %0d nonzero sdo cycles want 0", bad_sdo); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", obs_q.size()); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0000", rsp_rdata); end
  endtask

`ifdef SER_MASTER_FIFO_EN
  task automatic test_fifo();
    logic [15:0] e;
    obs_t o;
    bit ok;
    int w [5];
    @(posedge clk);
    obs_q.delete(); exp_q.delete();
    do @(negedge clk); while (r_k != 5'd1);
    for (int i = 0; i < 4; i++) send(1'b0, 5'(i + 1), 16'h0, w[i]);
    checks++; if (w[0] + w[1] + w[2] + w[3] != 0) begin errors++; $display("FAIL fifo_accept4: waited %0d want 0", w[0] + w[1] + w[2] + w[3]); end
    send(1'b0, 5'd5, 16'h0, w[4]);
    // Fifth handshake lands in the launch slot, so the slot after it is 0.
    checks++; if (r_k !== 5'd0) begin errors++; $display("FAIL fifo_fifth_slot: got k=%0d after accept want 0", r_k); end
    checks++; if (w[4] == 0) begin errors++; $display("FAIL fifo_full_ready: fifth waited %0d want >0", w[4]); end
    for (int i = 0; i < 5; i++) begin
      next_rsp(o, ok);
      if (ok) begin
        e = exp_q.pop_front();
        checks++; if (o.d !== e) begin errors++; $display("FAIL fifo_order%0d: got %h want %h", i, o.d, e); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SER_MASTER_FIFO_EN
    test_fifo();
`endif
    @(posedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected: %0d responses missing", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
